// File: rtl/uart_tx_frame_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | uart_tx_frame_ctrl_if                                            |
// | Valid/ready word handshake between TX data source and framer.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | uart_tx_frame_ctrl                                               |
// | UART TX framer: FSM, shift register, parity, one-word hold buffer.|
// | Option macro: UART_TX_HOLD_BUF_EN (accept mid-frame, no gaps).   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter int PAR_EN    = 1,
    parameter int PAR_ODD   = 0,
    parameter int STOP_BITS = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           baud_tick,
    uart_tx_frame_ctrl_if.slave src,
    output logic                tx_out,
    output logic                busy,
    output logic                frame_done,
    output logic                data_lost
);

    localparam int                 CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic               ODD       = (PAR_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic                tx_nxt;
    logic                hold_full, hold_full_nxt;
    logic [DATA_W-1:0]   hold_data;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic                par_bit, par_nxt;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
    logic                stop_cnt, stop_cnt_nxt;
    logic                done_nxt;
    logic                busy_nxt;
    logic                load;
    logic                ready;
    logic                accept;

    // CHAIN enables the STOP->START path so a held word starts without an idle bit
`ifdef UART_TX_HOLD_BUF_EN
    localparam logic CHAIN = 1'b1;
    assign ready = ~hold_full;
`else
    localparam logic CHAIN = 1'b0;
    assign ready = (state == IDLE) & ~hold_full;
`endif

    assign src.in_ready = ready;
    assign accept       = src.in_valid & ready;

    always_comb begin
        state_nxt    = state;
        tx_nxt       = tx_out;
        shreg_nxt    = shreg;
        par_nxt      = par_bit;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        done_nxt     = 1'b0;
        load         = 1'b0;

        if (baud_tick) begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        load      = 1'b1;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end
                end
                START: begin
                    state_nxt   = DATA;
                    tx_nxt      = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = '0;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_nxt = 1'b0;
                        if (PAR_EN != 0) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        tx_nxt      = shreg[0];
                        shreg_nxt   = shreg >> 1;
                    end
                end
                PARITY: begin
                    state_nxt    = STOP;
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                end
                STOP: begin
                    if (stop_cnt == LAST_STOP) begin
                        done_nxt = 1'b1;
                        if (CHAIN && hold_full) begin
                            load      = 1'b1;
                            state_nxt = START;
                            tx_nxt    = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        stop_cnt_nxt = stop_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end
            endcase
        end

        // Parity is fixed when the word leaves the hold register
        if (load) begin
            shreg_nxt = hold_data;
            par_nxt   = (^hold_data) ^ ODD;
        end

        hold_full_nxt = hold_full;
        if (load) begin
            hold_full_nxt = 1'b0;
        end else if (accept) begin
            hold_full_nxt = 1'b1;
        end

        busy_nxt = (state_nxt != IDLE) | hold_full_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            data_lost  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx_out     <= tx_nxt;
            hold_full  <= hold_full_nxt;
            shreg      <= shreg_nxt;
            par_bit    <= par_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
            data_lost  <= src.in_valid & ~ready;
            if (accept) begin
                hold_data <= src.in_data;
            end
        end
    end

endmodule
`default_nettype wire
